alu_mc: RTL

//  Parametrised multi-cycle ALU; successor to the 8-bit combinational datapath ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 76 +++++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, controller states and op-class helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOR  = 4'd2,
        OP_AND  = 4'd3,
        OP_XOR  = 4'd4,
        OP_RSH1 = 4'd5,
        OP_ADC  = 4'd6,
        OP_SBC  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SHL  = 4'd9,
        OP_ASR  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    // Variable-distance shifts are the only ops that may take the iterative path.
    function automatic logic is_var_shift(input logic [3:0] opCode);
        return (opCode == OP_SHR) || (opCode == OP_SHL) || (opCode == OP_ASR);
    endfunction

    function automatic logic uses_carry_in(input logic [3:0] opCode);
        return (opCode == OP_ADC) || (opCode == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU datapath: every op in one combinational step, shifts via a barrel shifter.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             c
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]      shiftAmt;
    logic                carryIn;
    logic [WIDTH:0]      sumExt;
    logic [WIDTH:0]      diffExt;
    logic [WIDTH:0]      carryExt;
    logic [WIDTH:0]      shrExt;
    logic [WIDTH:0]      shlExt;
    logic signed [WIDTH:0] asrIn;
    logic [WIDTH:0]      asrExt;

    assign shiftAmt = b[SHW-1:0];
    assign carryIn  = cin & uses_carry_in(op);
    assign carryExt = {{WIDTH{1'b0}}, carryIn};

    // Bit WIDTH of the extended sum/difference is the carry or borrow.
    assign sumExt  = {1'b0, a} + {1'b0, b} + carryExt;
    assign diffExt = {1'b0, a} - {1'b0, b} - carryExt;

    // An extra guard bit catches the last bit shifted out; distance 0 leaves it clear.
    assign shrExt = {a, 1'b0} >> shiftAmt;
    assign shlExt = {1'b0, a} << shiftAmt;
    assign asrIn  = {a, 1'b0};
    assign asrExt = asrIn >>> shiftAmt;

    always_comb begin
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                r = sumExt[WIDTH-1:0];
                c = sumExt[WIDTH];
            end
            OP_SUB, OP_SBC: begin
                r = diffExt[WIDTH-1:0];
                c = diffExt[WIDTH];
            end
            OP_NOR:  r = ~(a | b);
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_RSH1: r = a >> 1;
            OP_SHR: begin
                r = shrExt[WIDTH:1];
                c = shrExt[0];
            end
            OP_SHL: begin
                r = shlExt[WIDTH-1:0];
                c = shlExt[WIDTH];
            end
            OP_ASR: begin
                r = asrExt[WIDTH:1];
                c = asrExt[0];
            end
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, optional bit-serial shifts and sticky C/Z flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit ITER_SHIFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             flag_c,
    output logic             flag_z
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    alu_state_e       state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             outValid_q;
    logic             flagC_q;
    logic             flagZ_q;

    logic [WIDTH-1:0] coreR;
    logic             coreC;
    logic             startIter;
    logic [WIDTH-1:0] work_d;
    logic             stepC;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .op  (op),
        .cin (flagC_q),
        .r   (coreR),
        .c   (coreC)
    );

    // Zero-distance shifts finish in one cycle through the core like any other op.
    assign startIter = ITER_SHIFT && is_var_shift(op) && (b[SHW-1:0] != '0);

    // One bit of the latched shift per cycle; stepC is the bit falling off this step.
    always_comb begin
        work_d = work_q;
        stepC  = 1'b0;
        case (op_q)
            OP_SHR: begin
                work_d = {1'b0, work_q[WIDTH-1:1]};
                stepC  = work_q[0];
            end
            OP_SHL: begin
                work_d = {work_q[WIDTH-2:0], 1'b0};
                stepC  = work_q[WIDTH-1];
            end
            OP_ASR: begin
                work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                stepC  = work_q[0];
            end
            default: begin
                work_d = work_q;
                stepC  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            outValid_q <= 1'b0;
            flagC_q    <= 1'b0;
            flagZ_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (startIter) begin
                            work_q  <= a;
                            cnt_q   <= b[SHW-1:0];
                            state_q <= SHIFT;
                        end else begin
                            result_q   <= coreR;
                            cout_q     <= coreC;
                            flagC_q    <= coreC;
                            flagZ_q    <= (coreR == '0);
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    // The final step publishes straight into the output registers.
                    if (cnt_q == CNT_ONE) begin
                        result_q   <= work_d;
                        cout_q     <= stepC;
                        flagC_q    <= stepC;
                        flagZ_q    <= (work_d == '0);
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = ~|result_q;
    assign flag_c    = flagC_q;
    assign flag_z    = flagZ_q;

endmodule
